// File: rtl/cnn_pkg.sv
// Shared CNN datapath widths, pooling FSM state type and small helpers.
package cnn_pkg;
  localparam int ACC_W   = 32;
  localparam int ACT_W   = 8;
  localparam int ACT_MAX = 127;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } pool_state_t;

  function automatic logic [ACT_W-2:0] max_act(input logic [ACT_W-2:0] a,
                                               input logic [ACT_W-2:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/relu_quant.sv
// ReLU followed by arithmetic right-shift requantization with saturation to 0..127.
module relu_quant
  import cnn_pkg::*;
#(
  parameter int unsigned SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] din,
  output logic        [ACT_W-2:0] q
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    q       = '0;
    if (!din[ACC_W-1]) begin
      // din is non-negative here, so any bit above bit 6 means > ACT_MAX
      if (|shifted[ACC_W-1:ACT_W-1]) q = (ACT_W-1)'(ACT_MAX);
      else                           q = shifted[ACT_W-2:0];
    end
  end

endmodule

// File: rtl/relu_pool_quant.sv
// Streaming ReLU + int8 requantization + 2x2 stride-2 max pooling over one feature map.
module relu_pool_quant
  import cnn_pkg::*;
#(
  parameter int unsigned IN_SIZE = 28,
  parameter int unsigned SHIFT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACT_W-1:0] out_data,
  output logic                    frame_done
);

  localparam int unsigned   CW   = $clog2(IN_SIZE);
  localparam int unsigned   HALF = IN_SIZE / 2;
  localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);

  pool_state_t state, state_next;

  logic [CW-1:0]    row, col;
  logic [ACT_W-2:0] q, h, out_q, pool_q;
  logic [ACT_W-2:0] line_buf [HALF];
  logic             accept, out_xfer, last_elem;

  relu_quant #(.SHIFT(SHIFT)) u_relu_quant (
    .din (in_data),
    .q   (q)
  );

  assign out_xfer   = out_valid && out_ready;
  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_elem  = (row == LAST) && (col == LAST);
  assign pool_q     = max_act(line_buf[col[CW-1:1]], max_act(h, q));
  assign out_data   = {1'b0, out_q};
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && last_elem) state_next = DRAIN;
      DRAIN:   if (out_xfer) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      h         <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_xfer) out_valid <= 1'b0;
      if (accept) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          h <= q;
        end else if (row[0]) begin
          // reload wins over the clear above when a new window completes during a transfer
          out_q     <= pool_q;
          out_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) line_buf[col[CW-1:1]] <= max_act(h, q);
  end

endmodule

// File: tb/tb_relu_pool_quant.sv
// Directed scoreboard bench for relu_pool_quant at IN_SIZE=4 and IN_SIZE=28, SHIFT=8.
module tb_relu_pool_quant;

  int n_assert = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done;
  logic signed [31:0] a_in_data;
  logic signed [7:0]  a_out_data;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic signed [31:0] b_in_data;
  logic signed [7:0]  b_out_data;

  relu_pool_quant #(.IN_SIZE(4), .SHIFT(8)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .frame_done(a_frame_done)
  );

  relu_pool_quant #(.IN_SIZE(28), .SHIFT(8)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .frame_done(b_frame_done)
  );

  int frame [784];
  int expq  [$];

  function automatic int quant(input int v);
    int s;
    if (v < 0) return 0;
    s = v >>> 8;
    return (s > 127) ? 127 : s;
  endfunction

  function automatic int maxi(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit big, input logic v, input int d, input logic r);
    if (big) begin
      b_in_valid = v; b_in_data = d; b_out_ready = r;
    end else begin
      a_in_valid = v; a_in_data = d; a_out_ready = r;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_a_in_ready",   a_in_ready,   1);
    check("rst_a_out_valid",  a_out_valid,  0);
    check("rst_a_out_data",   a_out_data,   0);
    check("rst_a_frame_done", a_frame_done, 0);
    check("rst_b_in_ready",   b_in_ready,   1);
    check("rst_b_out_valid",  b_out_valid,  0);
    check("rst_b_out_data",   b_out_data,   0);
    check("rst_b_frame_done", b_frame_done, 0);
  endtask

  task automatic fill_rand(input int size);
    for (int i = 0; i < size * size; i++)
      frame[i] = int'($urandom_range(0, 60000)) - 20000;
  endtask

  // Streams frame[] into the selected instance; expected pooled values are pushed
  // when the window-completing input is accepted and popped on each output transfer.
  task automatic run_frame(input bit big, input int abort_after, input int stall_idx,
                           input bit chk_first);
    int   size  = big ? 28 : 4;
    int   total = size * size;
    int   nout  = (size / 2) * (size / 2);
    int   in_idx = 0, out_cnt = 0, stall_left = 0, cyc = 0;
    bit   stalled = 0, done_exp = 0, lat_pending = 0, finished = 0;
    logic v, r, ir, ov, fd;
    logic [7:0] od, held;
    int   rr, cc, e;
    expq.delete();
    held = '0;
    while (!finished) begin
      if (cyc > total * 3 + 100) begin
        n_assert++;
        n_fail++;
        $error("FAIL timeout: observed %0d outputs, expected %0d", out_cnt, nout);
        break;
      end
      @(negedge clk);
      cyc++;
      if (abort_after >= 0 && in_idx >= abort_after) return;
      v = (in_idx < total);
      r = (stall_left == 0);
      drive(big, v, v ? frame[in_idx] : 0, r);
      #1;
      ov = big ? b_out_valid : a_out_valid;
      od = big ? b_out_data  : a_out_data;
      if (!stalled && stall_idx >= 0 && ov && out_cnt == stall_idx) begin
        stalled    = 1;
        stall_left = 5;
        held       = od;
        r          = 1'b0;
        drive(big, v, v ? frame[in_idx] : 0, r);
        #1;
      end
      ir = big ? b_in_ready   : a_in_ready;
      ov = big ? b_out_valid  : a_out_valid;
      od = big ? b_out_data   : a_out_data;
      fd = big ? b_frame_done : a_frame_done;

      check("frame_done", fd, done_exp);
      if (done_exp) finished = 1;
      if (lat_pending) begin
        check("latency_valid", ov, 1);
        check("first_out", od, 3);
        lat_pending = 0;
      end
      if (stall_left > 0) begin
        check("bp_in_ready", ir, 0);
        check("bp_stable", od, held);
        stall_left--;
      end else if (v) begin
        check("in_ready", ir, 1);
      end

      if (ov && r) begin
        if (expq.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL unexpected_out: observed %0d, expected no output", od);
        end else begin
          e = expq.pop_front();
          check("out_data", od, e);
        end
        out_cnt++;
        if (out_cnt == nout) done_exp = 1;
      end

      if (v && ir) begin
        rr = in_idx / size;
        cc = in_idx % size;
        if ((rr % 2 == 1) && (cc % 2 == 1))
          expq.push_back(maxi(maxi(quant(frame[(rr-1)*size + cc-1]), quant(frame[(rr-1)*size + cc])),
                              maxi(quant(frame[rr*size + cc-1]),     quant(frame[rr*size + cc]))));
        if (chk_first && in_idx == 5) lat_pending = 1;
        in_idx++;
      end
    end
    check("out_count", out_cnt, nout);
    check("queue_empty", expq.size(), 0);
    // inputs after DONE must be refused
    repeat (3) begin
      @(negedge clk);
      drive(big, 1'b1, 1000, 1'b1);
      #1;
      check("done_in_ready",  big ? b_in_ready   : a_in_ready,   0);
      check("done_out_valid", big ? b_out_valid  : a_out_valid,  0);
      check("done_held",      big ? b_frame_done : a_frame_done, 1);
    end
    drive(big, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b1);

    // top-left window {256, 512, -1000, 768} -> 3
    apply_reset();
    fill_rand(4);
    frame[0] = 256; frame[1] = 512; frame[4] = -1000; frame[5] = 768;
    run_frame(1'b0, -1, -1, 1'b1);

    // all negative -> all zero
    apply_reset();
    for (int i = 0; i < 16; i++) frame[i] = -5000;
    run_frame(1'b0, -1, -1, 1'b0);

    // saturation and sub-LSB value
    apply_reset();
    for (int i = 0; i < 16; i++) frame[i] = 0;
    frame[11] = 40000;
    frame[2]  = 255;
    run_frame(1'b0, -1, -1, 1'b0);

    // backpressure on the second output
    apply_reset();
    fill_rand(4);
    run_frame(1'b0, -1, 1, 1'b0);

    // full-size ramp with continuous flow
    apply_reset();
    for (int i = 0; i < 784; i++) frame[i] = 256 * i;
    run_frame(1'b1, -1, -1, 1'b0);

    // mid-frame reset then a fresh frame with backpressure
    apply_reset();
    fill_rand(28);
    run_frame(1'b1, 50, -1, 1'b0);
    apply_reset();
    fill_rand(28);
    run_frame(1'b1, -1, 10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
